// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared event codes, unknown-key index and FSM states for the IR key event block
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_SWITCH = 2'd2
  } ir_state_t;

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_REPEAT  = 2'b10;
  localparam logic [1:0] EVT_RELEASE = 2'b11;

  localparam logic [5:0] IDX_UNKNOWN = 6'h3F;

  function automatic logic [7:0] mk_evt(input logic [1:0] typ, input logic [5:0] idx);
    return {typ, idx};
  endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// rtl/ir_evt_fifo.sv - event FIFO with registered head, drop-on-full and sticky overflow flag
module ir_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk27,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] wr_tdata,
  input  logic             wr_tvalid,
  input  logic             rd,
  input  logic             ovf_clr,
  output logic             rd_tvalid,
  output logic [WIDTH-1:0] rd_tdata,
  output logic             ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_rd;
  logic             do_wr;
  logic [WIDTH-1:0] head_nxt;

  // A pop frees a slot first, so a full FIFO read in the same cycle still accepts the write.
  always_comb begin
    do_rd      = rd && (count != '0);
    do_wr      = wr_tvalid && ((count != (AW+1)'(DEPTH)) || do_rd);
    rd_ptr_nxt = do_rd ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    if (count_nxt == '0)
      head_nxt = '0;
    else if (do_wr && (rd_ptr_nxt == wr_ptr))
      head_nxt = wr_tdata;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk27) begin
    if (do_wr)
      mem[wr_ptr] <= wr_tdata;
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_tdata <= '0;
      ovf      <= 1'b0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_tdata <= head_nxt;
      if (wr_tvalid && !do_wr)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  assign rd_tvalid = (count != '0);

endmodule

// File: rtl/ir_key_evt.sv
// rtl/ir_key_evt.sv - maps IR codes to key indices and queues PRESS/REPEAT/RELEASE events
// Optional: IR_UNKNOWN_EVT_EN reports unmatched non-zero codes as key 0x3F.
module ir_key_evt
  import ir_pkg::*;
#(
  parameter int NUM_KEYS     = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int RPT_DELAY    = 4,
  parameter int RPT_INTERVAL = 2
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic [15:0] ir_code,
  input  logic        ir_code_ack,
  input  logic [7:0]  ir_code_cnt,
  input  logic        cfg_we,
  input  logic [5:0]  cfg_idx,
  input  logic [15:0] cfg_code,
  input  logic        evt_rd,
  output logic        evt_valid,
  output logic [7:0]  evt_data,
  output logic        evt_ovf,
  input  logic        evt_ovf_clr,
  output logic        held_valid,
  output logic [5:0]  held_idx
);

  localparam logic [7:0] RPT_DELAY8    = 8'(RPT_DELAY);
  localparam logic [7:0] RPT_INTERVAL8 = 8'(RPT_INTERVAL);

  logic [15:0] key_tab [NUM_KEYS];

  ir_state_t   state;
  ir_state_t   state_nxt;
  logic [5:0]  held_q;
  logic [5:0]  held_nxt;
  logic [5:0]  pend_idx;
  logic [5:0]  pend_nxt;
  logic [7:0]  rpt_ref;
  logic [7:0]  rpt_nxt;
  logic [7:0]  cnt_prev;
  logic        ev_tvalid;
  logic [7:0]  ev_tdata;
  logic        ev_wr_nxt;
  logic [7:0]  ev_dat_nxt;

  logic        hit;
  logic [5:0]  hit_idx;
  logic        cnt_step;

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++)
        key_tab[i] <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_KEYS; i++)
        if (cfg_idx == 6'(i))
          key_tab[i] <= cfg_code;
    end
  end

  // Scan downwards so the lowest matching index is the last one assigned.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if ((key_tab[i] != '0) && (key_tab[i] == ir_code)) begin
        hit     = 1'b1;
        hit_idx = 6'(i);
      end
    end
`ifdef IR_UNKNOWN_EVT_EN
    if (!hit && (ir_code != '0)) begin
      hit     = 1'b1;
      hit_idx = IDX_UNKNOWN;
    end
`endif
  end

  assign cnt_step = (ir_code_cnt == cnt_prev + 8'd1);

  always_comb begin
    state_nxt  = state;
    ev_wr_nxt  = 1'b0;
    ev_dat_nxt = '0;
    held_nxt   = held_q;
    pend_nxt   = pend_idx;
    rpt_nxt    = rpt_ref;
    case (state)
      ST_IDLE: begin
        if (ir_code_ack && hit) begin
          ev_wr_nxt  = 1'b1;
          ev_dat_nxt = mk_evt(EVT_PRESS, hit_idx);
          held_nxt   = hit_idx;
          rpt_nxt    = RPT_DELAY8;
          state_nxt  = ST_HELD;
        end
      end
      ST_HELD: begin
        if (ir_code_ack) begin
          if (hit && (hit_idx == held_q)) begin
            rpt_nxt = RPT_DELAY8;
          end else begin
            ev_wr_nxt  = 1'b1;
            ev_dat_nxt = mk_evt(EVT_RELEASE, held_q);
            pend_nxt   = hit_idx;
            state_nxt  = hit ? ST_SWITCH : ST_IDLE;
          end
        end else if (ir_code == '0) begin
          ev_wr_nxt  = 1'b1;
          ev_dat_nxt = mk_evt(EVT_RELEASE, held_q);
          state_nxt  = ST_IDLE;
        end else if (cnt_step && (ir_code_cnt == rpt_ref)) begin
          ev_wr_nxt  = 1'b1;
          ev_dat_nxt = mk_evt(EVT_REPEAT, held_q);
          rpt_nxt    = rpt_ref + RPT_INTERVAL8;
        end
      end
      ST_SWITCH: begin
        ev_wr_nxt  = 1'b1;
        ev_dat_nxt = mk_evt(EVT_PRESS, pend_idx);
        held_nxt   = pend_idx;
        rpt_nxt    = RPT_DELAY8;
        state_nxt  = ST_HELD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      held_q    <= '0;
      pend_idx  <= '0;
      rpt_ref   <= '0;
      cnt_prev  <= '0;
      ev_tvalid <= 1'b0;
      ev_tdata  <= '0;
    end else begin
      state     <= state_nxt;
      held_q    <= held_nxt;
      pend_idx  <= pend_nxt;
      rpt_ref   <= rpt_nxt;
      cnt_prev  <= ir_code_cnt;
      ev_tvalid <= ev_wr_nxt;
      ev_tdata  <= ev_dat_nxt;
    end
  end

  assign held_valid = (state == ST_HELD);
  assign held_idx   = held_q;

  ir_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk27     (clk27),
    .reset_n   (reset_n),
    .wr_tdata  (ev_tdata),
    .wr_tvalid (ev_tvalid),
    .rd        (evt_rd),
    .ovf_clr   (evt_ovf_clr),
    .rd_tvalid (evt_valid),
    .rd_tdata  (evt_data),
    .ovf       (evt_ovf)
  );

endmodule
